// File: rtl/sd_dma_sched_if.sv
// Memory write port of the SD DMA scheduler: address-incrementing
// valid/ready beats carrying one 32-bit word each.
interface sd_dma_sched_if;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_ready;

    modport master (
        output m_valid,
        output m_addr,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_addr,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/sd_dma_sched.sv
// SD-card DMA transfer scheduler: sequences the sector-read engine, packs
// halfwords into words, buffers {addr,data} in a FIFO and drains it to memory.
module sd_dma_sched #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic [31:0] cfg_sec_addr,
    input  logic [16:0] cfg_sec_num,
    input  logic [31:0] cfg_dst_addr,
    input  logic        irq_clr,
    output logic        busy,
    output logic        done,
    output logic        irq,
    output logic        aborted,
    output logic        err_ovf,
    output logic        rd_start,
    output logic [31:0] rd_sec_addr,
    output logic [16:0] rd_sec_num,
    input  logic        rd_wr_en,
    input  logic [15:0] rd_wr_data,
    input  logic        rd_wr_last,
    sd_dma_sched_if.master mem
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] sec_addr_r;
    logic [16:0] sec_num_r;
    logic [31:0] dst_r;
    logic [23:0] total_r;
    logic [23:0] push_idx_r;
    logic [15:0] half_r;
    logic        half_vld_r;
    logic        abort_r;
    logic        busy_r;
    logic        done_r;
    logic        irq_r;
    logic        aborted_r;
    logic        err_ovf_r;
    logic        rd_start_r;
    logic        m_valid_r;
    logic [31:0] m_addr_r;
    logic [31:0] m_data_r;
    logic [63:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;

    logic [AW:0] fifo_cnt_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        slot_free_s;
    logic        half_fire_s;
    logic        push_s;
    logic        pop_en_s;
    logic        pop_s;
    logic        wr_ok_s;
    logic        ovf_s;
    logic [23:0] push_idx_nxt_s;
    logic [31:0] push_addr_s;
    logic [63:0] head_s;

    // Datapath decisions for this cycle; an abort pulse blocks both push and pop
    always_comb begin
        fifo_cnt_s     = wptr_r - rptr_r;
        fifo_empty_s   = (fifo_cnt_s == '0);
        fifo_full_s    = (fifo_cnt_s == PTR_FULL);
        slot_free_s    = !m_valid_r || mem.m_ready;
        half_fire_s    = (state_r == ST_RUN) && !cfg_abort && rd_wr_en;
        push_s         = half_fire_s && half_vld_r;
        pop_en_s       = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && !abort_r && !cfg_abort;
        pop_s          = pop_en_s && !fifo_empty_s && slot_free_s;
        wr_ok_s        = push_s && (!fifo_full_s || pop_s);
        ovf_s          = push_s && fifo_full_s && !pop_s;
        push_idx_nxt_s = push_idx_r + (push_s ? 24'd1 : 24'd0);
        push_addr_s    = dst_r + {6'd0, push_idx_r, 2'b00};
        head_s         = fifo_mem_r[rptr_r[AW-1:0]];
    end

    // FIFO storage; second halfword lands in [31:16]
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            fifo_mem_r[wptr_r[AW-1:0]] <= {push_addr_s, rd_wr_data, half_r};
        end
    end

    // Transfer FSM, FIFO pointers, memory port and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sec_addr_r <= 32'd0;
            sec_num_r  <= 17'd0;
            dst_r      <= 32'd0;
            total_r    <= 24'd0;
            push_idx_r <= 24'd0;
            half_r     <= 16'd0;
            half_vld_r <= 1'b0;
            abort_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            irq_r      <= 1'b0;
            aborted_r  <= 1'b0;
            err_ovf_r  <= 1'b0;
            rd_start_r <= 1'b0;
            m_valid_r  <= 1'b0;
            m_addr_r   <= 32'd0;
            m_data_r   <= 32'd0;
            wptr_r     <= '0;
            rptr_r     <= '0;
        end else begin
            done_r <= 1'b0;
            if (irq_clr) begin
                irq_r <= 1'b0;
            end
            if (wr_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r    <= rptr_r + PTR_ONE;
                m_valid_r <= 1'b1;
                m_addr_r  <= head_s[63:32];
                m_data_r  <= head_s[31:0];
            end else if (mem.m_ready) begin
                m_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        sec_addr_r <= cfg_sec_addr;
                        sec_num_r  <= cfg_sec_num;
                        dst_r      <= {cfg_dst_addr[31:2], 2'b00};
                        total_r    <= {cfg_sec_num, 7'd0};
                        push_idx_r <= 24'd0;
                        half_vld_r <= 1'b0;
                        abort_r    <= 1'b0;
                        aborted_r  <= 1'b0;
                        err_ovf_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        if (cfg_sec_num != 17'd0) begin
                            state_r    <= ST_RUN;
                            rd_start_r <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            irq_r   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_abort) begin
                        abort_r    <= 1'b1;
                        rd_start_r <= 1'b0;
                        state_r    <= ST_DRAIN;
                    end else begin
                        if (half_fire_s) begin
                            half_r     <= rd_wr_data;
                            half_vld_r <= !half_vld_r;
                        end
                        push_idx_r <= push_idx_nxt_s;
                        if (ovf_s) begin
                            err_ovf_r <= 1'b1;
                        end
                        // Engine says "all read": a short count is reported as overflow
                        if (rd_wr_last) begin
                            rd_start_r <= 1'b0;
                            state_r    <= ST_DRAIN;
                            if (push_idx_nxt_s != total_r) begin
                                err_ovf_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_r || cfg_abort) begin
                        abort_r <= 1'b1;
                        rptr_r  <= wptr_r;
                        if (slot_free_s) begin
                            state_r   <= ST_DONE;
                            done_r    <= 1'b1;
                            irq_r     <= 1'b1;
                            aborted_r <= 1'b1;
                        end
                    end else if (fifo_empty_s && slot_free_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        irq_r   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    half_vld_r <= 1'b0;
                    abort_r    <= 1'b0;
                    irq_r      <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    rd_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign irq         = irq_r;
    assign aborted     = aborted_r;
    assign err_ovf     = err_ovf_r;
    assign rd_start    = rd_start_r;
    assign rd_sec_addr = sec_addr_r;
    assign rd_sec_num  = sec_num_r;
    assign mem.m_valid = m_valid_r;
    assign mem.m_addr  = m_addr_r;
    assign mem.m_data  = m_data_r;
endmodule

// File: tb/tb_sd_dma_sched.sv
// Randomized bench for sd_dma_sched; every memory beat is checked against
// the word list built from the halfwords fed in.
module tb_sd_dma_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [31:0] cfg_sec_addr = 32'd0;
    logic [16:0] cfg_sec_num = 17'd0;
    logic [31:0] cfg_dst_addr = 32'd0;
    logic        irq_clr = 1'b0;
    logic        busy, done, irq, aborted, err_ovf, rd_start;
    logic [31:0] rd_sec_addr;
    logic [16:0] rd_sec_num;
    logic        rd_wr_en = 1'b0;
    logic [15:0] rd_wr_data = 16'd0;
    logic        rd_wr_last = 1'b0;

    sd_dma_sched_if mem_if ();

    sd_dma_sched #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_sec_addr(cfg_sec_addr), .cfg_sec_num(cfg_sec_num), .cfg_dst_addr(cfg_dst_addr),
        .irq_clr(irq_clr), .busy(busy), .done(done), .irq(irq),
        .aborted(aborted), .err_ovf(err_ovf), .rd_start(rd_start),
        .rd_sec_addr(rd_sec_addr), .rd_sec_num(rd_sec_num),
        .rd_wr_en(rd_wr_en), .rd_wr_data(rd_wr_data), .rd_wr_last(rd_wr_last),
        .mem(mem_if)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] hw [0:511];
    logic [31:0] b_addr [$];
    logic [31:0] b_data [$];
    int          done_cnt;
    bit          saw_rd, saw_mv;
    bit          hold_v = 1'b0;
    logic [31:0] hold_a, hold_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record this cycle's handshake (inputs already driven), then advance one clock.
    task automatic cycle();
        if (hold_v) begin
            chk("m_hold_valid", 64'(mem_if.m_valid), 64'd1);
            chk("m_hold_beat", {mem_if.m_addr, mem_if.m_data}, {hold_a, hold_d});
        end
        if (mem_if.m_valid && mem_if.m_ready) begin
            b_addr.push_back(mem_if.m_addr);
            b_data.push_back(mem_if.m_data);
        end
        if (done) done_cnt++;
        if (rd_start) saw_rd = 1'b1;
        if (mem_if.m_valid) saw_mv = 1'b1;
        hold_v = mem_if.m_valid && !mem_if.m_ready;
        hold_a = mem_if.m_addr;
        hold_d = mem_if.m_data;
        @(negedge clk);
    endtask

    task automatic clear_rec();
        b_addr.delete();
        b_data.delete();
        done_cnt = 0;
        saw_rd = 1'b0;
        saw_mv = 1'b0;
    endtask

    task automatic start(input logic [31:0] sa, input logic [16:0] sn, input logic [31:0] dst);
        cfg_sec_addr = sa;
        cfg_sec_num  = sn;
        cfg_dst_addr = dst;
        cfg_start    = 1'b1;
        cycle();
        cfg_start    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ":busy"}, 64'(busy), 64'd0);
        chk({nm, ":done"}, 64'(done), 64'd0);
        chk({nm, ":irq"}, 64'(irq), 64'd0);
        chk({nm, ":aborted"}, 64'(aborted), 64'd0);
        chk({nm, ":err_ovf"}, 64'(err_ovf), 64'd0);
        chk({nm, ":rd_start"}, 64'(rd_start), 64'd0);
        chk({nm, ":rd_sec"}, {15'd0, rd_sec_num, rd_sec_addr}, 64'd0);
        chk({nm, ":m_valid"}, 64'(mem_if.m_valid), 64'd0);
        chk({nm, ":m_beat"}, {mem_if.m_addr, mem_if.m_data}, 64'd0);
    endtask

    // Full transfer; expected words are built from the halfword list.
    task automatic run_xfer(input string nm, input logic [16:0] sn, input logic [31:0] dst,
                            input int en_pct, input int rdy_pct, input int stall,
                            input bit seq_data, input bit poke_start, input bit want_ovf);
        int          nh, total, idx, cyc, guard, prev;
        logic [31:0] sa, base;
        nh    = int'(sn) * 256;
        total = int'(sn) * 128;
        sa    = $urandom;
        base  = {dst[31:2], 2'b00};
        for (int i = 0; i < nh; i++) hw[i] = seq_data ? 16'(i) : 16'($urandom);
        clear_rec();
        start(sa, sn, dst);
        chk({nm, ":start_rd"}, 64'(rd_start), 64'd1);
        chk({nm, ":start_busy"}, 64'(busy), 64'd1);
        chk({nm, ":rd_sec"}, {15'd0, rd_sec_num, rd_sec_addr}, {15'd0, sn, sa});
        chk({nm, ":start_clr"}, {62'd0, aborted, err_ovf}, 64'd0);
        idx = 0;
        cyc = 0;
        while (idx < nh && cyc < 20000) begin
            rd_wr_en       = ($urandom_range(99) < en_pct);
            rd_wr_data     = rd_wr_en ? hw[idx] : 16'($urandom);
            mem_if.m_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (poke_start && cyc == 50) begin
                cfg_sec_addr = ~sa;
                cfg_sec_num  = sn + 17'd1;
                cfg_dst_addr = dst + 32'h100;
                cfg_start    = 1'b1;
            end
            cycle();
            cfg_start = 1'b0;
            if (rd_wr_en) idx++;
            cyc++;
        end
        if (poke_start) chk({nm, ":rd_sec_kept"}, {15'd0, rd_sec_num, rd_sec_addr}, {15'd0, sn, sa});
        rd_wr_en   = 1'b0;
        rd_wr_last = 1'b1;
        guard = 0;
        while (rd_start && guard < 100) begin
            mem_if.m_ready = ($urandom_range(99) < rdy_pct);
            cycle();
            guard++;
        end
        rd_wr_last = 1'b0;
        chk({nm, ":rd_start_drop"}, 64'(rd_start), 64'd0);
        guard = 0;
        while (!done && guard < 5000) begin
            mem_if.m_ready = ($urandom_range(99) < rdy_pct);
            cycle();
            guard++;
        end
        chk({nm, ":done_seen"}, 64'(done), 64'd1);
        cycle();
        mem_if.m_ready = 1'b1;
        cycle();
        cycle();
        chk({nm, ":done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, ":irq"}, 64'(irq), 64'd1);
        chk({nm, ":busy_end"}, 64'(busy), 64'd0);
        chk({nm, ":aborted"}, 64'(aborted), 64'd0);
        chk({nm, ":ovf_vs_loss"}, 64'(err_ovf), 64'(b_addr.size() != total));
        if (want_ovf) chk({nm, ":ovf_expected"}, 64'(err_ovf), 64'd1);
        else          chk({nm, ":beat_count"}, 64'(b_addr.size()), 64'(total));
        if (seq_data && b_addr.size() > 0)
            chk({nm, ":first_beat"}, {b_addr[0], b_data[0]}, {base, 32'h0001_0000});
        prev = -1;
        for (int k = 0; k < b_addr.size(); k++) begin
            logic [31:0] off;
            int          wi;
            off = b_addr[k] - base;
            wi  = int'(off >> 2);
            chk({nm, ":beat_align"}, 64'(off[1:0]), 64'd0);
            chk({nm, ":beat_order"}, 64'(wi > prev && wi < total), 64'd1);
            if (wi >= 0 && wi < total)
                chk({nm, ":beat_data"}, 64'(b_data[k]), {32'd0, hw[2*wi+1], hw[2*wi]});
            prev = wi;
        end
    endtask

    initial begin
        int          guard;
        logic [31:0] ha, hd, base;
        mem_if.m_ready = 1'b0;
        clear_rec();

        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk_reset_outputs("reset");

        run_xfer("seq1", 17'd1, 32'h0000_1000, 100, 100, 0, 1'b1, 1'b0, 1'b0);

        // zero-length run and irq set/clear priority
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("irq_clear", 64'(irq), 64'd0);
        clear_rec();
        start(32'h55, 17'd0, 32'h3000);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_irq", 64'(irq), 64'd1);
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("irq_set_prio", 64'(irq), 64'd1);
        chk("zero_done_drop", {62'd0, done, busy}, 64'd0);
        cycle();
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("irq_clear_late", 64'(irq), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_no_rd_mv", {62'd0, saw_rd, saw_mv}, 64'd0);

        run_xfer("ovf", 17'd2, 32'h0000_8000, 100, 100, 300, 1'b0, 1'b0, 1'b1);
        run_xfer("poke", 17'd1, 32'h0000_4006, 60, 80, 0, 1'b0, 1'b1, 1'b0);

        // abort with a beat held by back-pressure
        clear_rec();
        base = 32'h0000_2000;
        for (int i = 0; i < 256; i++) hw[i] = 16'($urandom);
        start(32'h77, 17'd1, base);
        mem_if.m_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rd_wr_en   = 1'b1;
            rd_wr_data = hw[i];
            cycle();
        end
        rd_wr_en = 1'b0;
        mem_if.m_ready = 1'b0;
        guard = 0;
        while (!mem_if.m_valid && guard < 50) begin
            cycle();
            guard++;
        end
        chk("abort_held", 64'(mem_if.m_valid), 64'd1);
        ha = mem_if.m_addr;
        hd = mem_if.m_data;
        cfg_abort = 1'b1;
        cycle();
        cfg_abort = 1'b0;
        chk("abort_rd_start", 64'(rd_start), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd_wr_en   = 1'b1;
            rd_wr_data = 16'($urandom);
            cycle();
        end
        rd_wr_en = 1'b0;
        mem_if.m_ready = 1'b1;
        guard = 0;
        while (!done && guard < 100) begin
            cycle();
            guard++;
        end
        chk("abort_done_seen", 64'(done), 64'd1);
        cycle();
        cycle();
        cycle();
        chk("abort_done_cnt", 64'(done_cnt), 64'd1);
        chk("abort_status", {61'd0, aborted, err_ovf, irq}, 64'b101);
        chk("abort_nonempty", 64'(b_addr.size() > 0), 64'd1);
        chk("abort_max", 64'(b_addr.size() <= 40), 64'd1);
        if (b_addr.size() > 0) begin
            chk("abort_last_beat", {b_addr[b_addr.size()-1], b_data[b_data.size()-1]}, {ha, hd});
        end
        for (int k = 0; k < b_addr.size(); k++) begin
            chk("abort_beat", {b_addr[k], b_data[k]}, {base + 32'(4*k), hw[2*k+1], hw[2*k]});
        end

        // reset in the middle of a transfer with beats pending
        clear_rec();
        start(32'h99, 17'd1, 32'h0000_6000);
        mem_if.m_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rd_wr_en   = 1'b1;
            rd_wr_data = 16'($urandom);
            cycle();
        end
        rd_wr_en = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        hold_v = 1'b0;
        chk_reset_outputs("mid_reset");

        for (int r = 0; r < 4; r++) begin
            run_xfer("rand", 17'($urandom_range(2, 1)), $urandom,
                     int'($urandom_range(60, 30)), int'($urandom_range(100, 50)),
                     0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/sd_dma_sched.md
# sd_dma_sched

Transfer scheduler for the SD-card DMA path. Software programs a start sector, sector count and destination address. The block then:
- sequences the SD sector-read engine over the whole run;
- packs its 16-bit read stream into 32-bit words and buffers them in a FIFO;
- issues address-incrementing valid/ready memory writes;
- reports completion, abort and overflow through status and a sticky interrupt.

It sits between the register file and the sector-read engine / memory write port.

## Interface
- FIFO_DEPTH, 16: buffer entries ({addr,data}, 64 bits each); power of two, ≥4.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_abort  in  1  one-cycle abort pulse; honoured in RUN/DRAIN.
- cfg_sec_addr  in  32  first SD sector.
- cfg_sec_num  in  17  sector count.
- cfg_dst_addr  in  32  destination byte address; bits[1:0] forced to 0.
- irq_clr  in  1  clears irq.
- busy  out  1  high in RUN/DRAIN/DONE.
- done  out  1  one-cycle pulse at end of transfer (normal, abort or zero-length).
- irq  out  1  sticky; set with done.
- aborted  out  1  status of last transfer; cleared on accepted start.
- err_ovf  out  1  sticky FIFO overflow of current/last transfer; cleared on accepted start.
- rd_start  out  1  level start to the sector-read engine.
- rd_sec_addr  out  32  latched cfg_sec_addr.
- rd_sec_num  out  17  latched cfg_sec_num.
- rd_wr_en  in  1  halfword valid from the read engine.
- rd_wr_data  in  16  halfword.
- rd_wr_last  in  1  engine's level "all sectors read" flag.
- m_valid  out  1  memory write request.
- m_addr  out  32  word address (byte units, 4-aligned).
- m_data  out  32  write data.
- m_ready  in  1  memory accepts beat when m_valid & m_ready.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - On cfg_start with cfg_sec_num≠0: latch config, clear aborted/err_ovf/counters, go to RUN.
  - On cfg_start with cfg_sec_num=0: go directly to DONE; no rd_start and no writes.
  - rd_wr_en is ignored in IDLE.
- RUN
  - rd_start=1.
  - Packing is little-endian: the first halfword goes to [15:0] and the second to [31:16]. The word is pushed on the second halfword.
  - The push address is dst + 4·push_idx. push_idx increments on every packed word.
  - Expected words: total = sec_num·128 (512 B/sector), 24-bit arithmetic.
  - Leave RUN when rd_wr_last=1 **and** push_idx==total; go to DRAIN with rd_start=0.
  - If rd_wr_last rises while push_idx≠total: set err_ovf and go to DRAIN anyway.
- Overflow: a push while the FIFO is full drops the word but still advances push_idx (address sequence preserved), sets err_ovf, and the transfer continues.
- DRAIN
  - rd_start=0; pop the FIFO to the memory port.
  - When the FIFO is empty and no beat is outstanding, go to DONE.
  - Halfwords arriving in DRAIN are ignored.
- DONE (one cycle): done=1, irq set, go to IDLE. A half-filled pack register is discarded.
- Abort in RUN/DRAIN
  - rd_start drops next cycle and further rd_wr_en is ignored.
  - An in-flight beat (m_valid & !m_ready) completes first; the remaining FIFO contents are then flushed.
  - Then DONE with aborted=1.
- cfg_start outside IDLE is ignored. cfg_abort in IDLE/DONE is ignored.
- irq: set (DONE) has priority over irq_clr in the same cycle.

## Timing
- Reset: every output 0, FSM in IDLE, FIFO empty, counters 0.
- cfg_start at edge N: rd_start=1, busy=1 and rd_sec_* valid after edge N.
- Second halfword at edge T: FIFO write at T; m_valid may assert after T+1. All outputs are registered.
- m_valid/m_addr/m_data hold stable until accepted; m_valid never drops without m_ready.
- Pop and push in the same cycle with FIFO full is a legal push (no overflow).
- Zero-length run: cfg_start at N → done pulse in cycle N+1 → IDLE at N+2.
- Throughput: one memory beat per cycle with m_ready=1.
- rst_n low mid-transfer: everything returns to reset values next edge; the FIFO is flushed.

## Test plan
- sec_num=1, dst=0x1000, halfwords 0x0000..0x00FF, m_ready=1 → 128 writes at 0x1000..0x11FC; first data 0x00010000; done pulse once; irq=1, err_ovf=0.
- cfg_sec_num=0 → done pulse in cycle after start; no rd_start, no m_valid; irq=1.
- sec_num=2, m_ready low for 300 cycles, FIFO_DEPTH=16 → err_ovf=1. Surviving writes carry correct addresses (dst+4·idx) and the transfer still ends with done.
- Abort after 40 words while m_valid & !m_ready → the held beat completes, then no more writes; aborted=1; rd_start low next cycle; done pulse.
- irq_clr asserted in the same cycle as DONE → irq stays 1. irq_clr a later cycle → irq=0.
- cfg_start pulsed in RUN → ignored; latched rd_sec_addr/num unchanged; single done at end.
